// File: rtl/adder_pkg.sv
// Shared types for the adding-machine control sequencer: opcodes, state
// encoding and the bundle of datapath strobes.
package adder_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADI = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // A bus-error halt has no state of its own: it is S_IDLE with bus_error set.
  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_IDLE   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_LDA    = 3'd4,
    S_STA    = 3'd5,
    S_ADI    = 3'd6,
    S_JMP    = 3'd7
  } state_e;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic acc_on_dbus;
    logic load_ir;
    logic load_acc;
    logic sel_alu;
    logic sel_bus;
    logic pass_add;
    logic ld_pc;
    logic clr_pc;
    logic inc_pc;
    logic ir_on_adr;
    logic pc_on_adr;
    logic instr_done;
  } strobes_t;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_LDA) || (s == S_STA);
  endfunction

endpackage

// File: rtl/adder_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath plus memory model (slave).
interface adder_ctrl_if;
  logic       run;
  logic [1:0] opcode;
  logic       mem_ready;
  logic       mem_rd;
  logic       mem_wr;
  logic       acc_on_dbus;
  logic       load_IR;
  logic       load_acc;
  logic       sel_alu;
  logic       sel_bus;
  logic       pass_add;
  logic       ld_pc;
  logic       clr_pc;
  logic       inc_pc;
  logic       ir_on_adr;
  logic       pc_on_adr;
  logic       instr_done;
  logic       bus_error;
  logic [2:0] state_dbg;

  modport master (
    input  run, opcode, mem_ready,
    output mem_rd, mem_wr, acc_on_dbus, load_IR, load_acc, sel_alu, sel_bus,
           pass_add, ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr,
           instr_done, bus_error, state_dbg
  );

  modport slave (
    output run, opcode, mem_ready,
    input  mem_rd, mem_wr, acc_on_dbus, load_IR, load_acc, sel_alu, sel_bus,
           pass_add, ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr,
           instr_done, bus_error, state_dbg
  );
endinterface

// File: rtl/adder_wait_timer.sv
// Counts cycles spent waiting on mem_ready; hit_o flags that the
// configured limit has been reached (never, when WAIT_LIMIT is 0).
module adder_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/adder_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit adding machine: drives the
// datapath strobes and a ready-based handshake to program memory.
module adder_ctrl
  import adder_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input logic          clock,
  input logic          reset,
  adder_ctrl_if.master ctrl_if
);
  state_e   state_q;
  state_e   state_d;
  logic     bus_error_q;
  logic     bus_error_d;
  strobes_t str;
  logic     in_mem;
  logic     wait_clr;
  logic     wait_en;
  logic     wait_hit;
  logic     timeout;

  // Counter is held clear outside memory states and on each completed access.
  assign in_mem   = is_mem_state(state_q);
  assign wait_clr = !in_mem || ctrl_if.mem_ready;
  assign wait_en  = in_mem && !ctrl_if.mem_ready;
  assign timeout  = wait_en && wait_hit;

  adder_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (wait_clr),
    .en_i  (wait_en),
    .hit_o (wait_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_RST:    state_d = ctrl_if.run ? S_FETCH : S_IDLE;
      S_IDLE: begin
        if (ctrl_if.run && !bus_error_q) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (ctrl_if.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d     = S_IDLE;
          bus_error_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (ctrl_if.opcode)
          OP_LDA:  state_d = S_LDA;
          OP_STA:  state_d = S_STA;
          OP_ADI:  state_d = S_ADI;
          OP_JMP:  state_d = S_JMP;
          default: state_d = S_IDLE;
        endcase
      end
      S_LDA, S_STA: begin
        // A ready arriving on the limit cycle completes the access.
        if (ctrl_if.mem_ready) begin
          state_d = ctrl_if.run ? S_FETCH : S_IDLE;
        end else if (timeout) begin
          state_d     = S_IDLE;
          bus_error_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_ADI, S_JMP: state_d = ctrl_if.run ? S_FETCH : S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Only load_IR/inc_pc/sel_bus/load_acc/instr_done depend on mem_ready.
  always_comb begin
    str = '0;
    case (state_q)
      S_RST: str.clr_pc = 1'b1;
      S_FETCH: begin
        str.pc_on_adr = 1'b1;
        str.mem_rd    = 1'b1;
        str.load_ir   = ctrl_if.mem_ready;
        str.inc_pc    = ctrl_if.mem_ready;
      end
      S_LDA: begin
        str.ir_on_adr  = 1'b1;
        str.mem_rd     = 1'b1;
        str.sel_bus    = ctrl_if.mem_ready;
        str.load_acc   = ctrl_if.mem_ready;
        str.instr_done = ctrl_if.mem_ready;
      end
      S_STA: begin
        str.ir_on_adr   = 1'b1;
        str.mem_wr      = 1'b1;
        str.acc_on_dbus = 1'b1;
        str.instr_done  = ctrl_if.mem_ready;
      end
      S_ADI: begin
        str.sel_alu    = 1'b1;
        str.pass_add   = 1'b1;
        str.load_acc   = 1'b1;
        str.instr_done = 1'b1;
      end
      S_JMP: begin
        str.ld_pc      = 1'b1;
        str.instr_done = 1'b1;
      end
      default: str = '0;
    endcase
  end

  assign ctrl_if.mem_rd      = str.mem_rd;
  assign ctrl_if.mem_wr      = str.mem_wr;
  assign ctrl_if.acc_on_dbus = str.acc_on_dbus;
  assign ctrl_if.load_IR     = str.load_ir;
  assign ctrl_if.load_acc    = str.load_acc;
  assign ctrl_if.sel_alu     = str.sel_alu;
  assign ctrl_if.sel_bus     = str.sel_bus;
  assign ctrl_if.pass_add    = str.pass_add;
  assign ctrl_if.ld_pc       = str.ld_pc;
  assign ctrl_if.clr_pc      = str.clr_pc;
  assign ctrl_if.inc_pc      = str.inc_pc;
  assign ctrl_if.ir_on_adr   = str.ir_on_adr;
  assign ctrl_if.pc_on_adr   = str.pc_on_adr;
  assign ctrl_if.instr_done  = str.instr_done;
  assign ctrl_if.bus_error   = bus_error_q;
  assign ctrl_if.state_dbg   = state_q;

endmodule
